// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the stage-2 memory responder: control-word fields, selector codes and
// FSM states. Also imported by stage-2 benches.
package mem_bus_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StWait,
    StDone,
    StDma
  } state_e;

  typedef enum logic [2:0] {
    AddrNone  = 3'd0,
    AddrPcra0 = 3'd1,
    AddrPcra1 = 3'd2,
    AddrSp    = 3'd3,
    AddrSi    = 3'd4,
    AddrDi    = 3'd5,
    AddrTx    = 3'd6,
    AddrRsvd  = 3'd7
  } addr_sel_e;

  localparam logic [3:0] SelMem    = 4'hF;
  localparam int unsigned BusReqBit = 13;

  function automatic logic [3:0] assert_sel(input logic [15:0] word);
    return word[3:0];
  endfunction

  function automatic logic [3:0] load_sel(input logic [15:0] word);
    return word[7:4];
  endfunction

  function automatic addr_sel_e addr_sel(input logic [15:0] word);
    return addr_sel_e'(word[12:10]);
  endfunction

endpackage

// File: rtl/mem_bus_responder_addr_mux.sv
// Combinational address-source mux: selects one of six 16-bit sources, 0 for codes 0 and 7.
module mem_addr_mux
  import mem_bus_responder_pkg::*;
(
  input  addr_sel_e   sel_i,
  input  logic [15:0] pcra0_i,
  input  logic [15:0] pcra1_i,
  input  logic [15:0] sp_i,
  input  logic [15:0] si_i,
  input  logic [15:0] di_i,
  input  logic [15:0] tx_i,
  output logic [15:0] addr_o
);

  always_comb begin
    addr_o = '0;
    unique case (sel_i)
      AddrPcra0: addr_o = pcra0_i;
      AddrPcra1: addr_o = pcra1_i;
      AddrSp:    addr_o = sp_i;
      AddrSi:    addr_o = si_i;
      AddrDi:    addr_o = di_i;
      AddrTx:    addr_o = tx_i;
      default:   addr_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the stage-2 control word: runs one read or write with wait states,
// a ready handshake and timeout, stalls the pipeline meanwhile, and hands the bus to DMA.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] controls_in,
  input  logic        ctl_valid,
  input  logic [15:0] pcra0,
  input  logic [15:0] pcra1,
  input  logic [15:0] sp,
  input  logic [15:0] si,
  input  logic [15:0] di,
  input  logic [15:0] tx,
  input  logic [7:0]  bus_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        dma_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  bus_rdata,
  output logic        rdata_valid,
  output logic        stall,
  output logic        dma_grant,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  bus_rdata_q, bus_rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        fault_q, fault_d;
  logic        mem_req_q, stall_q, dma_grant_q;
  logic        mem_req_d, stall_d, dma_grant_d;

  logic        rd, wr, access, illegal;
  addr_sel_e   asel;
  logic [15:0] src_addr;

  logic unused_ctl;
  assign unused_ctl = ^{controls_in[15:14], controls_in[9:8]};

  assign rd      = (assert_sel(controls_in) == SelMem);
  assign wr      = (load_sel(controls_in) == SelMem);
  assign asel    = addr_sel(controls_in);
  assign access  = rd | wr;
  assign illegal = (rd & wr) | (access & ((asel == AddrNone) | (asel == AddrRsvd)));

  mem_addr_mux u_addr_mux (
    .sel_i   (asel),
    .pcra0_i (pcra0),
    .pcra1_i (pcra1),
    .sp_i    (sp),
    .si_i    (si),
    .di_i    (di),
    .tx_i    (tx),
    .addr_o  (src_addr)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    bus_rdata_d   = bus_rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctl_valid) begin
          if (illegal) begin
            fault_d = 1'b1;
          end else if (access) begin
            mem_addr_d  = src_addr;
            mem_wdata_d = bus_wdata;
            mem_we_d    = wr;
            cnt_d       = '0;
            state_d     = (WAIT_STATES == 0) ? StWait : StAccess;
          end else if (controls_in[BusReqBit] && dma_req) begin
            state_d = StDma;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWait: begin
        // Ready wins over a timeout landing on the same cycle.
        if (mem_ready) begin
          state_d = StDone;
          if (!mem_we_q) begin
            bus_rdata_d   = mem_rdata;
            rdata_valid_d = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == 4'(TIMEOUT - 1))) begin
          fault_d  = 1'b1;
          mem_we_d = 1'b0;
          state_d  = StIdle;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        mem_we_d = 1'b0;
        state_d  = StIdle;
      end
      StDma: begin
        if (!dma_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    mem_req_d   = (state_d == StAccess) || (state_d == StWait);
    stall_d     = mem_req_d || (state_d == StDma);
    dma_grant_d = (state_d == StDma);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      bus_rdata_q   <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      stall_q       <= 1'b0;
      dma_grant_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      bus_rdata_q   <= bus_rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
      mem_req_q     <= mem_req_d;
      stall_q       <= stall_d;
      dma_grant_q   <= dma_grant_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_req     = mem_req_q;
  assign bus_rdata   = bus_rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign stall       = stall_q;
  assign dma_grant   = dma_grant_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized scoreboard bench for mem_bus_responder: the driver queues expected events, a negedge
// monitor pops and checks them as the DUT produces accesses, faults and grants.
module tb_mem_bus_responder;

  localparam int unsigned WS = 1;
  localparam int unsigned TO = 15;

  localparam int KNone  = 0;
  localparam int KAcc   = 1;
  localparam int KTmo   = 2;
  localparam int KFault = 3;
  localparam int KGrant = 4;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] controls_in;
  logic        ctl_valid;
  logic [15:0] src [1:6];
  logic [7:0]  bus_wdata, mem_rdata;
  logic        mem_ready, dma_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, bus_rdata;
  logic        mem_req, mem_we, rdata_valid, stall, dma_grant, fault;

  exp_t        exp_q[$];
  exp_t        cur, mon_e;
  int          checks = 0;
  int          errors = 0;
  int          req_len = 0;
  logic        req_prev = 1'b0, grant_prev = 1'b0;
  logic [7:0]  last_rdata = 8'h00;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .WAIT_STATES (WS),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .controls_in (controls_in),
    .ctl_valid   (ctl_valid),
    .pcra0       (src[1]),
    .pcra1       (src[2]),
    .sp          (src[3]),
    .si          (src[4]),
    .di          (src[5]),
    .tx          (src[6]),
    .bus_wdata   (bus_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .dma_req     (dma_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .bus_rdata   (bus_rdata),
    .rdata_valid (rdata_valid),
    .stall       (stall),
    .dma_grant   (dma_grant),
    .fault       (fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic pop(output exp_t e);
    if (exp_q.size() == 0) begin
      e = '{kind: KNone, addr: '0, we: 1'b0, wdata: '0, rdata: '0, len: 0};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      req_prev   = 1'b0;
      grant_prev = 1'b0;
      req_len    = 0;
    end else begin
      chk("stall_busy", {31'b0, stall}, {31'b0, mem_req | dma_grant});
      if (mem_req && !req_prev) begin
        pop(cur);
        req_len = 0;
        chk("access_expected", {31'b0, (cur.kind == KAcc) || (cur.kind == KTmo)}, 32'd1);
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, cur.addr});
        chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
        if (cur.we) chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, cur.wdata});
      end
      if (mem_req) req_len++;
      if (!mem_req && req_prev) begin
        chk("req_cycles", req_len, cur.len);
        chk("rdata_valid_done", {31'b0, rdata_valid}, {31'b0, (cur.kind == KAcc) && !cur.we});
        chk("fault_done", {31'b0, fault}, {31'b0, cur.kind == KTmo});
        if (!cur.we || cur.kind == KTmo) chk("bus_rdata", {24'b0, bus_rdata}, {24'b0, cur.rdata});
      end else begin
        chk("rdata_valid_idle", {31'b0, rdata_valid}, 32'd0);
        if (fault) begin
          pop(mon_e);
          chk("fault_expected", mon_e.kind, KFault);
        end
      end
      if (dma_grant && !grant_prev) begin
        pop(mon_e);
        chk("grant_expected", mon_e.kind, KGrant);
      end
      req_prev   = mem_req;
      grant_prev = dma_grant;
    end
  end

  function automatic logic [15:0] mkword(input bit rd, input bit wr, input logic [2:0] asel,
                                         input bit b13);
    logic [15:0] w;
    logic [3:0]  a, l;
    w = 16'($urandom);
    a = 4'($urandom_range(0, 14));
    l = 4'($urandom_range(0, 14));
    if (rd) a = 4'hF;
    if (wr) l = 4'hF;
    w[3:0]   = a;
    w[7:4]   = l;
    w[12:10] = asel;
    w[13]    = b13;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shuffle();
    for (int i = 1; i <= 6; i++) src[i] = 16'($urandom);
    bus_wdata = 8'($urandom);
    mem_rdata = 8'($urandom);
  endtask

  // Words and sources presented while busy must be ignored.
  task automatic noise();
    shuffle();
    ctl_valid   = 1'($urandom);
    controls_in = 16'($urandom);
  endtask

  task automatic idle_tick();
    shuffle();
    ctl_valid = 1'b0;
    mem_ready = 1'($urandom);
    tick();
  endtask

  task automatic do_access(input bit is_wr, input logic [2:0] asel, input logic [15:0] aval,
                           input logic [7:0] val, input int d, input bit tmo, input bit b13,
                           input bit dreq);
    exp_t e;
    shuffle();
    src[asel] = aval;
    if (is_wr) bus_wdata = val;
    dma_req = dreq;
    e.kind  = tmo ? KTmo : KAcc;
    e.addr  = aval;
    e.we    = is_wr;
    e.wdata = bus_wdata;
    e.rdata = last_rdata;
    e.len   = tmo ? int'(WS + TO) : int'(WS) + d + 1;
    if (!tmo && !is_wr) begin
      e.rdata    = val;
      last_rdata = val;
    end
    exp_q.push_back(e);
    controls_in = mkword(!is_wr, is_wr, asel, b13);
    ctl_valid   = 1'b1;
    mem_ready   = 1'($urandom);
    tick();
    for (int i = 0; i < int'(WS); i++) begin
      noise();
      mem_ready = 1'($urandom);
      tick();
    end
    if (tmo) begin
      for (int i = 0; i < int'(TO); i++) begin
        noise();
        mem_ready = 1'b0;
        tick();
      end
    end else begin
      for (int i = 0; i < d; i++) begin
        noise();
        mem_ready = 1'b0;
        tick();
      end
      noise();
      mem_ready = 1'b1;
      if (!is_wr) mem_rdata = val;
      tick();
    end
    ctl_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) idle_tick();
    dma_req = 1'b0;
  endtask

  task automatic do_word(input logic [15:0] w, input bit is_fault, input bit dreq);
    exp_t e;
    if (is_fault) begin
      e = '{kind: KFault, addr: '0, we: 1'b0, wdata: '0, rdata: '0, len: 0};
      exp_q.push_back(e);
    end
    dma_req     = dreq;
    controls_in = w;
    ctl_valid   = 1'b1;
    tick();
    repeat (2) idle_tick();
    dma_req = 1'b0;
  endtask

  task automatic do_dma(input logic [15:0] w, input int hold);
    exp_t e;
    e = '{kind: KGrant, addr: '0, we: 1'b0, wdata: '0, rdata: '0, len: 0};
    exp_q.push_back(e);
    dma_req     = 1'b1;
    controls_in = w;
    ctl_valid   = 1'b1;
    tick();
    ctl_valid = 1'b0;
    @(negedge clk);
    chk("dma_grant_next", {31'b0, dma_grant}, 32'd1);
    chk("dma_stall", {31'b0, stall}, 32'd1);
    chk("dma_no_req", {31'b0, mem_req}, 32'd0);
    tick();
    for (int i = 0; i < hold; i++) begin
      noise();
      mem_ready = 1'($urandom);
      tick();
    end
    ctl_valid = 1'b0;
    dma_req   = 1'b0;
    tick();
    @(negedge clk);
    chk("dma_release_grant", {31'b0, dma_grant}, 32'd0);
    chk("dma_release_stall", {31'b0, stall}, 32'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_addr"}, {16'b0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 32'd0);
    chk({tag, "_bus_rdata"}, {24'b0, bus_rdata}, 32'd0);
    chk({tag, "_ctl_flags"},
        {23'b0, mem_req, mem_we, rdata_valid, stall, dma_grant, fault, 3'b0}, 32'd0);
  endtask

  task automatic reset_mid_wait();
    exp_t e;
    shuffle();
    e = '{kind: KAcc, addr: src[4], we: 1'b0, wdata: '0, rdata: '0, len: 0};
    exp_q.push_back(e);
    controls_in = mkword(1'b1, 1'b0, 3'd4, 1'b0);
    ctl_valid   = 1'b1;
    mem_ready   = 1'b0;
    tick();
    for (int i = 0; i < int'(WS) + 1; i++) begin
      noise();
      mem_ready = 1'b0;
      tick();
    end
    ctl_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    last_rdata = 8'h00;
    @(negedge clk);
    check_all_zero("mid_reset");
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    reset       = 1'b1;
    controls_in = '0;
    ctl_valid   = 1'b0;
    bus_wdata   = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;
    dma_req     = 1'b0;
    for (int i = 1; i <= 6; i++) src[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    do_access(1'b0, 3'd3, 16'h01F0, 8'hA5, 3, 1'b0, 1'b0, 1'b0);
    do_access(1'b1, 3'd6, 16'hBEEF, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
    do_word(16'h0CFF, 1'b1, 1'b0);
    do_word(16'h1CF0, 1'b1, 1'b0);
    do_access(1'b0, 3'd1, 16'h1234, 8'h77, 0, 1'b1, 1'b0, 1'b0);
    do_dma(16'h2000, 3);
    do_access(1'b0, 3'd3, 16'h0F0F, 8'h5A, 1, 1'b0, 1'b1, 1'b1);
    do_dma(mkword(1'b0, 1'b0, 3'd0, 1'b1), 1);
    reset_mid_wait();
    do_access(1'b0, 3'd2, 16'hC0DE, 8'hE1, 2, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        do_access(1'($urandom), 3'($urandom_range(1, 6)), 16'($urandom), 8'($urandom),
                  int'($urandom_range(0, 4)), 1'b0, 1'($urandom), 1'($urandom));
      end else if (op == 5) begin
        if ($urandom_range(0, 1) == 0) begin
          do_word(mkword(1'b1, 1'b1, 3'($urandom), 1'($urandom)), 1'b1, 1'($urandom));
        end else begin
          op = int'($urandom_range(0, 1));
          do_word(mkword(op == 0, op == 1, ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7,
                         1'($urandom)), 1'b1, 1'($urandom));
        end
      end else if (op == 6) begin
        do_word(mkword(1'b0, 1'b0, 3'($urandom), 1'b0), 1'b0, 1'($urandom));
      end else if (op == 7) begin
        do_dma(mkword(1'b0, 1'b0, 3'($urandom), 1'b1), int'($urandom_range(0, 4)));
      end else if (op == 8) begin
        do_access(1'b0, 3'($urandom_range(1, 6)), 16'($urandom), 8'($urandom), 0, 1'b1,
                  1'b0, 1'b0);
      end else begin
        do_word(mkword(1'b0, 1'b0, 3'($urandom), 1'b1), 1'b0, 1'b0);
      end
    end

    repeat (3) idle_tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
